systolic_mm_engine: RTL and testbench

Parametrised N×N output-stationary systolic matrix-multiply engine computing C = A·B (plus optional accumulation onto the previous C), the next-generation compute core of the TPU. Operands are streamed in with a valid/ready handshake, buffered, and then fed into the array with internal diagonal skew. Results are streamed out one row per beat with backpressure. This replaces the fixed 4×4, 4-bit, free-running divided-clock array with a single-clock, handshaked, width- and size-configurable engine.

---
 rtl/tpu_pkg.sv | 20 ++
 rtl/mac_pe.sv | 63 ++++++
 rtl/systolic_mm_engine.sv | 192 +++++++++++++++++++
 tb/tb_systolic_mm_engine.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared types and defaults for the systolic matrix-multiply engine.
package tpu_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCompute,
    StDrain
  } state_e;

  localparam int unsigned DefN  = 4;
  localparam int unsigned DefDW = 4;
  localparam int unsigned DefAW = 10;

  // Skewed wavefront needs 3N-2 cycles to reach the far corner PE.
  function automatic int unsigned compute_len(input int unsigned n);
    return 3 * n - 2;
  endfunction

endpackage

// File: rtl/mac_pe.sv
// Output-stationary multiply-accumulate cell with operand pass-through.
// Define TPU_ACC_SAT_EN to clamp on overflow instead of wrapping.
module mac_pe
  import tpu_pkg::*;
#(
  parameter int unsigned DW = DefDW,
  parameter int unsigned AW = DefAW
) (
  input  logic          clk,
  input  logic          res,
  input  logic          clr,
  input  logic          en,
  input  logic [DW-1:0] a_in,
  input  logic [DW-1:0] b_in,
  output logic [DW-1:0] a_out,
  output logic [DW-1:0] b_out,
  output logic [AW-1:0] acc_out,
  output logic          ovf
);

  logic [DW-1:0]   a_q, b_q;
  logic [AW-1:0]   acc_q, acc_d;
  logic            ovf_q;
  logic [2*DW-1:0] prod;
  logic [AW:0]     sum;

  assign prod = {{DW{1'b0}}, a_in} * {{DW{1'b0}}, b_in};
  assign sum  = {1'b0, acc_q} + (AW + 1)'(prod);

  always_comb begin
`ifdef TPU_ACC_SAT_EN
    acc_d = sum[AW] ? {AW{1'b1}} : sum[AW-1:0];
`else
    acc_d = sum[AW-1:0];
`endif
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      // Pipes return to zero outside compute so the next run starts clean.
      a_q <= en ? a_in : '0;
      b_q <= en ? b_in : '0;
      if (clr) begin
        acc_q <= '0;
        ovf_q <= 1'b0;
      end else if (en) begin
        acc_q <= acc_d;
        if (sum[AW]) ovf_q <= 1'b1;
      end
    end
  end

  assign a_out   = a_q;
  assign b_out   = b_q;
  assign acc_out = acc_q;
  assign ovf     = ovf_q;

endmodule

// File: rtl/systolic_mm_engine.sv
// N x N output-stationary systolic engine: buffered operand load, skewed feed,
// row-at-a-time result drain with backpressure.
module systolic_mm_engine
  import tpu_pkg::*;
#(
  parameter int unsigned N  = DefN,
  parameter int unsigned DW = DefDW,
  parameter int unsigned AW = DefAW
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 start,
  input  logic                 acc,
  output logic                 busy,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*DW-1:0]      in_a,
  input  logic [N*DW-1:0]      in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_row,
  output logic [N*AW-1:0]      out_data,
  output logic                 done,
  output logic                 ovf
);

  localparam int unsigned RW   = $clog2(N);
  localparam int unsigned CLen = compute_len(N);
  localparam int unsigned TW   = $clog2(CLen);

  state_e        state_q, state_d;
  logic [RW-1:0] k_q, k_d, row_q, row_d;
  logic [TW-1:0] t_q, t_d;
  logic          done_q, done_d;
  logic          clr_acc, pe_en, load_beat;

  logic [DW-1:0] a_buf [N][N];
  logic [DW-1:0] b_buf [N][N];
  logic [DW-1:0] a_feed [N];
  logic [DW-1:0] b_feed [N];
  logic [DW-1:0] a_pass [N][N];
  logic [DW-1:0] b_pass [N][N];
  logic [AW-1:0] acc_w [N][N];
  logic [N*N-1:0] pe_ovf;
  logic [N-1:0]  unused_a_edge, unused_b_edge;

  assign load_beat = (state_q == StLoad) && in_valid;
  assign pe_en     = (state_q == StCompute);

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    t_d     = t_q;
    row_d   = row_q;
    done_d  = 1'b0;
    clr_acc = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          k_d     = '0;
          clr_acc = !acc;
        end
      end
      StLoad: begin
        if (in_valid) begin
          if (k_q == RW'(N - 1)) begin
            state_d = StCompute;
            k_d     = '0;
            t_d     = '0;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      StCompute: begin
        if (t_q == TW'(CLen - 1)) begin
          state_d = StDrain;
          t_d     = '0;
          row_d   = '0;
        end else begin
          t_d = t_q + 1'b1;
        end
      end
      StDrain: begin
        if (out_ready) begin
          if (row_q == RW'(N - 1)) begin
            state_d = StIdle;
            row_d   = '0;
            done_d  = 1'b1;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_q <= StIdle;
      k_q     <= '0;
      t_q     <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          a_buf[i][k] <= '0;
          b_buf[i][k] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      t_q     <= t_d;
      row_q   <= row_d;
      done_q  <= done_d;
      if (load_beat) begin
        for (int i = 0; i < N; i++) begin
          a_buf[i][k_q] <= in_a[i*DW +: DW];
          b_buf[k_q][i] <= in_b[i*DW +: DW];
        end
      end
    end
  end

  // Row i / column j feeders are delayed by i / j cycles to form the wavefront.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      a_feed[i] = '0;
      b_feed[i] = '0;
      if (state_q == StCompute) begin
        for (int k = 0; k < N; k++) begin
          if (int'(t_q) == i + k) begin
            a_feed[i] = a_buf[i][k];
            b_feed[i] = b_buf[k][i];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      logic [DW-1:0] a_in, b_in;
      if (j == 0) begin : g_a_edge
        assign a_in = a_feed[i];
      end else begin : g_a_int
        assign a_in = a_pass[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in = b_feed[j];
      end else begin : g_b_int
        assign b_in = b_pass[i-1][j];
      end

      mac_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk    (clk),
        .res    (res),
        .clr    (clr_acc),
        .en     (pe_en),
        .a_in   (a_in),
        .b_in   (b_in),
        .a_out  (a_pass[i][j]),
        .b_out  (b_pass[i][j]),
        .acc_out(acc_w[i][j]),
        .ovf    (pe_ovf[i*N+j])
      );
    end
    assign unused_a_edge[i] = ^a_pass[i][N-1];
    assign unused_b_edge[i] = ^b_pass[N-1][i];
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < N; j++) begin
      out_data[j*AW +: AW] = acc_w[row_q][j];
    end
  end

  assign busy      = (state_q != StIdle);
  assign in_ready  = (state_q == StLoad);
  assign out_valid = (state_q == StDrain);
  assign out_row   = row_q;
  assign done      = done_q;
  assign ovf       = |pe_ovf;

endmodule

// File: tb/tb_systolic_mm_engine.sv
// Directed bench for systolic_mm_engine at N=4, DW=4, AW=10.
module tb_systolic_mm_engine;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 4;
  localparam int unsigned AW = 10;

  logic            clk = 1'b0;
  logic            res = 1'b0;
  logic            start = 1'b0;
  logic            acc = 1'b0;
  logic            busy;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [N*DW-1:0] in_a = '0;
  logic [N*DW-1:0] in_b = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [1:0]      out_row;
  logic [N*AW-1:0] out_data;
  logic            done;
  logic            ovf;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int done_pulses = 0;
  int ops = 0;
  int first_valid = 0;
  int done_cyc = 0;
  int ma[N][N];
  int mb[N][N];
  int mexp[N][N];

  systolic_mm_engine #(
    .N (N),
    .DW(DW),
    .AW(AW)
  ) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .acc      (acc),
    .busy     (busy),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_row  (out_row),
    .out_data (out_data),
    .done     (done),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_pulses++;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expected);
    vectors++;
    assert (obs === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expected);
    end
  endtask

  function automatic logic [N*AW-1:0] exp_row(input int r);
    logic [N*AW-1:0] v;
    for (int j = 0; j < N; j++) v[j*AW +: AW] = mexp[r][j][AW-1:0];
    return v;
  endfunction

  task automatic model();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        mexp[i][j] = 0;
        for (int k = 0; k < N; k++) mexp[i][j] += ma[i][k] * mb[k][j];
      end
    end
  endtask

  task automatic set_all(input int av, input int bv, input int ev);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = av;
        mb[i][j] = bv;
        mexp[i][j] = ev;
      end
    end
  endtask

  task automatic set_identity();
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (i == j) ? 1 : 0;
        mb[i][j] = 4 * i + j;
      end
    end
  endtask

  // Start pulse plus load phase; gap drops in_valid on odd cycles.
  task automatic begin_op(input bit accf, input bit gap, input bit noise);
    int k = 0;
    int g = 0;
    cyc = 0;
    start = 1'b1;
    acc = accf;
    step();
    start = 1'b0;
    acc = 1'b0;
    while (k < N && g < 64) begin
      in_valid = !(gap && (g % 2 == 1));
      for (int i = 0; i < N; i++) begin
        in_a[i*DW +: DW] = ma[i][k][DW-1:0];
        in_b[i*DW +: DW] = mb[k][i][DW-1:0];
      end
      if (!in_valid) begin
        in_a = '1;
        in_b = '1;
      end
      start = noise && (g == 1);
      if (in_valid && in_ready) k++;
      step();
      g++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    check("load beats", k, N);
  endtask

  task automatic finish_op(input int stall_row, input bit noise);
    int g = 0;
    while (!out_valid && g < 200) begin
      step();
      g++;
    end
    check("out_valid seen", out_valid, 1);
    first_valid = cyc;
    for (int r = 0; r < N; r++) begin
      if (r == stall_row) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          step();
          check("stall row", out_row, r);
          check("stall data", out_data, exp_row(r));
        end
      end
      out_ready = 1'b1;
      start = noise && (r == 0);
      check("row index", out_row, r);
      check($sformatf("row %0d data", r), out_data, exp_row(r));
      step();
      start = 1'b0;
    end
    out_ready = 1'b0;
    done_cyc = cyc;
    ops++;
    check("done pulse", done, 1);
    check("idle at done", busy, 0);
    step();
    check("done drops", done, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " in_ready"}, in_ready, 0);
    check({tag, " out_valid"}, out_valid, 0);
    check({tag, " out_row"}, out_row, 0);
    check({tag, " out_data"}, out_data, 0);
    check({tag, " done"}, done, 0);
    check({tag, " ovf"}, ovf, 0);
  endtask

  initial begin
    res = 1'b0;
    step();
    step();
    check_quiet("reset");
    res = 1'b1;
    step();

    // Identity: C = B, with exact cycle timing.
    set_identity();
    model();
    begin_op(1'b0, 1'b0, 1'b0);
    finish_op(-1, 1'b0);
    check("identity first out_valid cycle", first_valid, 15);
    check("identity done cycle", done_cyc, 19);
    check("identity ovf", ovf, 0);

    // All-max, fresh accumulators.
    set_all(15, 15, 900);
    begin_op(1'b0, 1'b0, 1'b0);
    finish_op(-1, 1'b0);
    check("allmax ovf", ovf, 0);

    // Tiled accumulation on top of 900.
`ifdef TPU_ACC_SAT_EN
    set_all(15, 15, 1023);
`else
    set_all(15, 15, 776);
`endif
    begin_op(1'b1, 1'b0, 1'b0);
    finish_op(-1, 1'b0);
    check("tiled ovf", ovf, 1);

    // in_valid in IDLE must not consume a beat.
    in_valid = 1'b1;
    in_a = '1;
    in_b = '1;
    step();
    step();
    check("idle in_valid ignored", busy, 0);
    in_valid = 1'b0;

    // Gapped load, row 2 backpressure, stray start pulses.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        ma[i][j] = i + j + 1;
        mb[i][j] = (i + 2 * j) % 16;
      end
    end
    model();
    begin_op(1'b0, 1'b1, 1'b1);
    finish_op(2, 1'b1);
    check("gap ovf cleared", ovf, 0);
    check("done per op", done_pulses, ops);

    // Reset at t=5 of compute.
    set_all(15, 15, 0);
    begin_op(1'b0, 1'b0, 1'b0);
    repeat (5) step();
    check("mid-compute busy", busy, 1);
    res = 1'b0;
    step();
    res = 1'b1;
    check_quiet("mid reset");

    // acc=1 after reset accumulates onto zeros.
    set_identity();
    model();
    begin_op(1'b1, 1'b0, 1'b0);
    finish_op(-1, 1'b0);
    check("post reset ovf", ovf, 0);
    check("done per op final", done_pulses, ops);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
